// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing pipeline stages.
package sc_pkg;

   localparam int unsigned SC_WIDTH = 8;
   localparam int unsigned SC_LEN   = (1 << SC_WIDTH) - 1;

   // Feedback taps q[7]^q[5]^q[4]^q[3] (x^8+x^6+x^5+x^4+1), maximal length.
   localparam logic [SC_WIDTH-1:0] SC_LFSR_TAPS = 8'hB8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GEN  = 2'd1,
      DONE = 2'd2
   } sc_state_e;

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR register; load has priority over step, zero seed becomes 1.
module sc_lfsr
   import sc_pkg::*;
#(
   parameter int unsigned          WIDTH = SC_WIDTH,
   parameter logic [WIDTH-1:0]     SEED  = WIDTH'(1),
   parameter logic [WIDTH-1:0]     TAPS  = WIDTH'(SC_LFSR_TAPS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   output logic [WIDTH-1:0] q
);

   // An all-zero state would lock the register, so it is never loaded.
   localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= SEED_EFF;
      end else if (load) begin
         q <= SEED_EFF;
      end else if (step) begin
         q <= {q[WIDTH-2:0], ^(q & TAPS)};
      end
   end

endmodule

// File: rtl/sc_stream_gen.sv
// Unipolar stochastic bitstream generator: LFSR vs. latched operand comparator,
// one stream bit per cycle over a full LFSR period.
module sc_stream_gen
   import sc_pkg::*;
#(
   parameter int unsigned WIDTH     = SC_WIDTH,
   parameter int unsigned LFSR_SEED = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [WIDTH-1:0]        a,
   output logic [(2**WIDTH)-2:0]   a_sbs,
   output logic                    busy,
   output logic                    done,
   output logic [WIDTH-1:0]        ones
);

   localparam int unsigned      LEN      = (1 << WIDTH) - 1;
   localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(LEN - 1);

   sc_state_e        state;
   sc_state_e        state_next;
   logic             load;
   logic             step;
   logic             busy_next;
   logic             done_next;
   logic             cmp;
   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] idx;

   sc_lfsr #(
      .WIDTH (WIDTH),
      .SEED  (WIDTH'(LFSR_SEED))
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .step (step),
      .q    (lfsr_q)
   );

   assign cmp = (lfsr_q <= a_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and datapath controls; start is only honoured outside GEN.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = GEN;
               load       = 1'b1;
            end
         end
         GEN: begin
            step = 1'b1;
            if (idx == LAST_IDX) begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next == GEN);
      done_next = (state_next == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q  <= '0;
         idx  <= '0;
         a_sbs <= '0;
         ones <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= busy_next;
         done <= done_next;
         if (load) begin
            a_q   <= a;
            idx   <= '0;
            a_sbs <= '0;
            ones  <= '0;
         end else if (step) begin
            a_sbs[idx] <= cmp;
            ones       <= WIDTH'(ones + WIDTH'(cmp));
            // Index parks on the last bit instead of running past the stream.
            if (idx != LAST_IDX) begin
               idx <= WIDTH'(idx + WIDTH'(1));
            end
         end
      end
   end

endmodule

// File: tb/tb_sc_stream_gen.sv
// Directed bench for sc_stream_gen: two generators (seeds 1 and 2) checked
// against a reference LFSR/comparator model through an expectation queue.
module tb_sc_stream_gen;
   import sc_pkg::*;

   localparam int unsigned W = SC_WIDTH;
   localparam int unsigned L = SC_LEN;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [L-1:0] sbs0, sbs1;
   logic         busy0, busy1, done0, done1;
   logic [W-1:0] ones0, ones1;

   typedef struct {
      logic [L-1:0] sbs0;
      logic [L-1:0] sbs1;
      logic [W-1:0] ones;
      int           and_cnt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   sc_stream_gen #(.WIDTH(W), .LFSR_SEED(1)) dut0 (
      .clk(clk), .rst(rst), .start(start), .a(a),
      .a_sbs(sbs0), .busy(busy0), .done(done0), .ones(ones0)
   );

   sc_stream_gen #(.WIDTH(W), .LFSR_SEED(2)) dut1 (
      .clk(clk), .rst(rst), .start(start), .a(a),
      .a_sbs(sbs1), .busy(busy1), .done(done1), .ones(ones1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [L-1:0] model_stream(input logic [W-1:0] seed,
                                                  input logic [W-1:0] op);
      logic [W-1:0] l;
      logic [L-1:0] s;
      l = seed;
      s = '0;
      for (int i = 0; i < int'(L); i++) begin
         s[i] = (l <= op);
         l    = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
      return s;
   endfunction

   task automatic check(input string tag, input logic [L-1:0] obs,
                        input logic [L-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [W-1:0] op);
      exp_t e;
      @(negedge clk);
      a     = op;
      start = 1'b1;
      e.sbs0    = model_stream(8'd1, op);
      e.sbs1    = model_stream(8'd2, op);
      e.ones    = op;
      e.and_cnt = $countones(e.sbs0 & e.sbs1);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for done, optionally pulsing start with a new operand mid-run.
   task automatic run_to_done(input int inject_at, input logic [W-1:0] inject_a);
      int   k;
      int   busy_cnt;
      exp_t e;
      k        = 0;
      busy_cnt = 0;
      while (!done0 && k < 300) begin
         if (busy0) busy_cnt++;
         if (k == inject_at) begin
            start = 1'b1;
            a     = inject_a;
         end
         @(negedge clk);
         start = 1'b0;
         k++;
      end
      check("latency", L'(k), L'(255));
      check("busy_cycles", L'(busy_cnt), L'(255));
      check("done_busy_excl", L'({busy0, done0, busy1, done1}), L'(4'b0101));
      if (sb.size() == 0) begin
         n_cmp++;
         n_fail++;
         $error("FAIL sb_empty: observed 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         check("sbs0_stream", sbs0, e.sbs0);
         check("sbs1_stream", sbs1, e.sbs1);
         check("ones0", L'(ones0), L'(e.ones));
         check("ones1", L'(ones1), L'(e.ones));
         check("popcnt0", L'($countones(sbs0)), L'(e.ones));
         check("popcnt1", L'($countones(sbs1)), L'(e.ones));
         check("and_popcnt", L'($countones(sbs0 & sbs1)), L'(e.and_cnt));
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", L'(busy0), L'(0));
      check("rst_done", L'(done0), L'(0));
      check("rst_ones", L'(ones0), L'(0));
      check("rst_sbs", sbs0, '0);
      rst = 1'b0;
      @(negedge clk);

      // Boundary operands: empty and full streams.
      start_op(8'd0);
      run_to_done(-1, 8'd0);
      check("a0_sbs_zero", sbs0, '0);

      start_op(8'd255);
      run_to_done(-1, 8'd0);
      check("a255_sbs_ones", sbs0, '1);
      check("a255_ones", L'(ones0), L'(255));

      start_op(8'd128);
      run_to_done(-1, 8'd0);
      check("a128_bit0", L'(sbs0[0]), L'(1'b1));
      check("a128_ones", L'(ones0), L'(128));

      start_op(8'hC0);
      run_to_done(-1, 8'd0);
      check("c0_ones0", L'(ones0), L'(192));
      check("c0_ones1", L'(ones1), L'(192));

      // Start during GEN must be ignored; then restart from DONE.
      start_op(8'hA5);
      run_to_done(100, 8'h3C);
      check("ignored_ones", L'(ones0), L'(8'hA5));
      start_op(8'd7);
      check("restart_done_drop", L'(done0), L'(0));
      check("restart_busy", L'(busy0), L'(1));
      run_to_done(-1, 8'd0);
      check("restart_ones", L'(ones0), L'(7));

      // Asynchronous reset between edges in the middle of a run.
      start_op(8'h55);
      repeat (50) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", L'(busy0), L'(0));
      check("arst_done", L'(done0), L'(0));
      check("arst_ones", L'(ones0), L'(0));
      check("arst_sbs", sbs0, '0);
      void'(sb.pop_front());
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("rst_wins_busy", L'(busy0), L'(0));
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_done", L'(done0), L'(0));
      check("post_rst_busy", L'(busy0), L'(0));

      start_op(8'd64);
      run_to_done(-1, 8'd0);
      check("a64_ones", L'(ones0), L'(64));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
